// File: rtl/mem_responder.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// mem_responder
//
// Behavioural SRAM-style memory target. An initiator requests an access by
// driving the active-low chip, read and write enables. The responder latches
// the address, byte-lane enables and write data on the sampling edge. It then
// waits WAIT_CYCLES cycles and completes the read or write. Read data is
// presented on a registered bus, followed one cycle later by a one-cycle
// valid pulse.
//
// Parameters
//   WAIT_CYCLES  wait states per access (legal 1..7; out-of-range is clamped)
//   DEPTH_BITS   log2 of the number of 16-bit words held
//
// Ports
//   Clk         in   system clock, rising edge
//   Reset       in   synchronous, active-high reset (storage is not cleared)
//   Mem_CE      in   chip enable, active-low; high during an access aborts it
//   Mem_OE      in   read enable, active-low
//   Mem_WE      in   write enable, active-low; wins over Mem_OE
//   Mem_UB      in   upper byte lane [15:8] enable, active-low
//   Mem_LB      in   lower byte lane [7:0] enable, active-low
//   ADDR        in   word address, wraps modulo 2**DEPTH_BITS
//   Data_in     in   write data
//   Data_out    out  registered read data, held between reads
//   Data_valid  out  one-cycle pulse marking fresh Data_out
//   Busy        out  high whenever the FSM is not idle
// -----------------------------------------------------------------------------
module mem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_BITS  = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Mem_CE,
  input  logic        Mem_OE,
  input  logic        Mem_WE,
  input  logic        Mem_UB,
  input  logic        Mem_LB,
  input  logic [19:0] ADDR,
  input  logic [15:0] Data_in,
  output logic [15:0] Data_out,
  output logic        Data_valid,
  output logic        Busy
);

  // Counter reload value. The wait count is kept inside a 3-bit counter, so
  // an illegal parameter is pulled back into 1..7 instead of wrapping.
  function automatic logic [2:0] wait_load(input int cycles);
    if (cycles < 1) begin
      return 3'd0;
    end else if (cycles > 7) begin
      return 3'd6;
    end else begin
      return 3'(cycles - 1);
    end
  endfunction

  localparam logic [2:0] CNT_LOAD = wait_load(WAIT_CYCLES);
  localparam int         WORDS    = 1 << DEPTH_BITS;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    WR_WAIT = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t                  state;
  state_t                  next_state;
  logic [2:0]              cnt;
  logic [DEPTH_BITS-1:0]   addr_lat;
  logic                    ub_en;
  logic                    lb_en;
  logic                    is_write;
  logic [15:0]             wdata;
  logic [15:0]             mem [WORDS];
  logic [15:0]             rd_word;

  logic                    req;
  logic                    start;
  logic                    mem_write;
  logic                    rd_load;
  logic                    valid_set;

  // Address bits above the array size are deliberately discarded (wrap).
  logic                    unused_addr_hi;
  assign unused_addr_hi = ^(ADDR >> DEPTH_BITS);

  assign req     = ~Mem_CE & (~Mem_OE | ~Mem_WE);
  assign rd_word = mem[addr_lat];

  // State register with synchronous reset taking priority over any access.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state decode: CE high in a wait state aborts back to idle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          next_state = Mem_WE ? RD_WAIT : WR_WAIT;
        end else begin
          next_state = IDLE;
        end
      end
      RD_WAIT, WR_WAIT: begin
        if (Mem_CE) begin
          next_state = IDLE;
        end else if (cnt == 3'd0) begin
          next_state = DONE;
        end else begin
          next_state = state;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Per-state action strobes; only the completing edge of a wait state acts.
  always_comb begin
    start     = 1'b0;
    mem_write = 1'b0;
    rd_load   = 1'b0;
    valid_set = 1'b0;
    case (state)
      IDLE: begin
        start = req;
      end
      RD_WAIT: begin
        rd_load = ~Mem_CE & (cnt == 3'd0);
      end
      WR_WAIT: begin
        mem_write = ~Mem_CE & (cnt == 3'd0) & ~Reset;
      end
      DONE: begin
        valid_set = ~is_write;
      end
      default: begin
        start = 1'b0;
      end
    endcase
  end

  // Request capture and wait-state counter; inputs are ignored until the
  // next sampling edge once an access is under way.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt      <= 3'd0;
      addr_lat <= '0;
      ub_en    <= 1'b0;
      lb_en    <= 1'b0;
      is_write <= 1'b0;
      wdata    <= 16'h0000;
    end else if (start) begin
      cnt      <= CNT_LOAD;
      addr_lat <= ADDR[DEPTH_BITS-1:0];
      ub_en    <= ~Mem_UB;
      lb_en    <= ~Mem_LB;
      is_write <= ~Mem_WE;
      if (!Mem_WE) begin
        wdata <= Data_in;
      end
    end else if (((state == RD_WAIT) || (state == WR_WAIT)) && (cnt != 3'd0)) begin
      cnt <= cnt - 3'd1;
    end
  end

  // Storage array with per-lane write enables; deliberately not reset.
  always_ff @(posedge Clk) begin
    if (mem_write) begin
      if (ub_en) begin
        mem[addr_lat][15:8] <= wdata[15:8];
      end
      if (lb_en) begin
        mem[addr_lat][7:0] <= wdata[7:0];
      end
    end
  end

  // Registered outputs: read data captured on completion, valid a cycle later.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Data_out   <= 16'h0000;
      Data_valid <= 1'b0;
      Busy       <= 1'b0;
    end else begin
      Data_valid <= valid_set;
      Busy       <= (next_state != IDLE);
      if (rd_load) begin
        Data_out <= {(ub_en ? rd_word[15:8] : 8'h00),
                     (lb_en ? rd_word[7:0]  : 8'h00)};
      end
    end
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameters SHALL be: WAIT_CYCLES, default 2, read/write wait states (legal range 1..7); DEPTH_BITS, default 8, log2 of the word count of the storage array.
REQ-002 Clk  input  1  system clock; all state changes occur on its rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 Mem_CE  input  1  chip enable, active-low.
REQ-005 Mem_OE  input  1  output (read) enable, active-low.
REQ-006 Mem_WE  input  1  write enable, active-low.
REQ-007 Mem_UB  input  1  upper byte lane [15:8] enable, active-low.
REQ-008 Mem_LB  input  1  lower byte lane [7:0] enable, active-low.
REQ-009 ADDR  input  20  word address; only ADDR[DEPTH_BITS-1:0] is used.
REQ-010 Data_in  input  16  write data from the initiator (MDR).
REQ-011 Data_out  output  16  registered read data.
REQ-012 Data_valid  output  1  one-cycle pulse marking fresh Data_out.
REQ-013 Busy  output  1  high whenever the state is not IDLE.

Function
REQ-014 The FSM SHALL have exactly the states IDLE, RD_WAIT, WR_WAIT and DONE.
REQ-015 IDLE: a request SHALL be sampled when Mem_CE=0 and either Mem_OE=0 or Mem_WE=0; otherwise the FSM SHALL stay in IDLE.
REQ-016 If Mem_WE=0 and Mem_OE=0 at the same time, the access SHALL be a write (WE has priority).
REQ-017 On the sampling edge, ADDR[DEPTH_BITS-1:0], Mem_UB, Mem_LB and, for writes, Data_in SHALL be latched; later changes to these inputs SHALL be ignored until the next access.
REQ-018 On the sampling edge, the wait counter SHALL load WAIT_CYCLES-1 and the FSM SHALL enter RD_WAIT (read) or WR_WAIT (write).
REQ-019 RD_WAIT/WR_WAIT: the counter SHALL decrement once per cycle; on the edge where the counter equals 0, the FSM SHALL go to DONE.
REQ-020 Read completion: on the RD_WAIT->DONE edge, Data_out[15:8] SHALL take mem[addr][15:8] if UB was enabled, else 8'h00; Data_out[7:0] SHALL take mem[addr][7:0] if LB was enabled, else 8'h00.
REQ-021 Data_valid SHALL be 1 only in the DONE state after a read, which is WAIT_CYCLES+1 edges after the sampling edge; with the default, a request sampled at edge 0 gives Data_valid high between edges 3 and 4.
REQ-022 Write completion: on the WR_WAIT->DONE edge, only the enabled byte lanes of mem[addr] SHALL be updated, using the latched data; disabled lanes SHALL stay unchanged.
REQ-023 Data_valid SHALL stay 0 for writes, and Data_out SHALL hold its previous value.
REQ-024 DONE SHALL always go to IDLE on the next edge; a request still held in IDLE SHALL start a new access, so a held OE gives repeated reads and a held WE repeats the same write.
REQ-025 Abort: if Mem_CE=1 is sampled in RD_WAIT or WR_WAIT, the FSM SHALL return to IDLE with no memory update, no Data_valid, and Data_out unchanged.
REQ-026 Releasing OE or WE mid-access while Mem_CE=0 SHALL NOT abort the access.
REQ-027 Addresses above the array size SHALL wrap modulo 2^DEPTH_BITS.
REQ-028 Data_out SHALL hold its last read value indefinitely between reads.

Reset
REQ-029 When Reset=1 at an edge, the FSM SHALL go to IDLE, the counter to 0, Data_out to 16'h0000, Data_valid to 0 and Busy to 0; this SHALL take priority over any in-flight access.
REQ-030 A reset during WR_WAIT SHALL leave the memory word unmodified.
REQ-031 Storage contents SHALL NOT be cleared by Reset.

Verification
REQ-032 Write 16'hBEEF to address 0x005 (UB=LB=0), then read 0x005 -> Data_valid pulses 3 edges after the read is sampled, with Data_out=16'hBEEF; Busy is high for exactly 3 cycles per access.
REQ-033 With 0x005 holding 16'hBEEF, write 16'h1234 with UB=1, LB=0, then read -> Data_out=16'hBE34; read with LB=1 -> Data_out=16'hBE00.
REQ-034 Start a write of 16'hAAAA to 0x010 (old value 16'h5555), raise Mem_CE one cycle later -> FSM returns to IDLE, a later read gives 16'h5555, and Data_valid is never asserted for the aborted access.
REQ-035 Assert WE=0 and OE=0 together with Data_in=16'h0F0F at 0x020 -> a write occurs and no Data_valid pulse appears; a following read returns 16'h0F0F.
REQ-036 Write 16'h7777 to ADDR=0x00103 (DEPTH_BITS=8), then read 0x00003 -> 16'h7777 (wrap-around).
REQ-037 Assert Reset in RD_WAIT -> next cycle Busy=0, Data_valid=0, Data_out=16'h0000; a following read completes normally.
